// File: rtl/retire_trace_tx_if.sv
// Retirement capture and trace-stream signals of retire_trace_tx.
// The master view belongs to the transmitter. The slave view belongs to the core and the sink.
interface retire_trace_tx_if;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic [31:0] retire_instr;
  logic        retire_reg_wr;
  logic [4:0]  retire_dest;
  logic [31:0] retire_wr_data;
  logic [31:0] v0_val;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_last;
  logic        tx_ready;

  modport master (
    input  retire_valid, retire_pc, retire_instr, retire_reg_wr, retire_dest, retire_wr_data,
           v0_val, tx_ready,
    output tx_valid, tx_data, tx_last
  );

  modport slave (
    output retire_valid, retire_pc, retire_instr, retire_reg_wr, retire_dest, retire_wr_data,
           v0_val, tx_ready,
    input  tx_valid, tx_data, tx_last
  );
endinterface

// File: rtl/retire_trace_tx.sv
// Retirement trace transmitter: buffers one record per retired instruction and serialises
// each record as four 32-bit beats on a valid/ready stream.
module retire_trace_tx #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic               clk,
  input  logic               reset,
  retire_trace_tx_if.master  bus,
  output logic               stall_req,
  output logic               overflow,
  output logic               end_seen,
  output logic               drain_done
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfCnt   = CntW'(DEPTH - AF_MARGIN);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic [31:0] data_mem  [DEPTH];
  logic [15:0] seq_mem   [DEPTH];
  logic        wr_mem    [DEPTH];
  logic [4:0]  dest_mem  [DEPTH];

  state_e          state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [1:0]      beat_q, beat_d;
  logic [15:0]     seq_q, seq_d;
  logic            overflow_q, overflow_d;
  logic            end_seen_q, end_seen_d;

  logic tx_fire, pop, push, full, keep_wr;

  always_comb begin
    tx_fire    = (state_q == StSend) && bus.tx_ready;
    pop        = tx_fire && (beat_q == 2'd3);
    full       = (count_q == FullCnt);
    // A full FIFO still accepts when the head leaves on this very edge.
    push       = bus.retire_valid && (!full || pop);
    keep_wr    = bus.retire_reg_wr && (bus.retire_dest != 5'd0);
    count_d    = count_q + CntW'(push) - CntW'(pop);
    beat_d     = tx_fire ? beat_q + 2'd1 : beat_q;
    wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    seq_d      = bus.retire_valid ? seq_q + 16'd1 : seq_q;
    overflow_d = overflow_q || (bus.retire_valid && !push);
    end_seen_d = end_seen_q || (push && (bus.retire_instr == 32'h0000_000C) &&
                                (bus.v0_val == 32'h0000_000A));
    state_d    = state_q;
    unique case (state_q)
      StIdle:  if (count_d != '0) state_d = StSend;
      StSend:  if (pop && (count_d == '0)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      end_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      end_seen_q <= end_seen_d;
    end
  end

  // Record storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pc_mem[wr_ptr_q]    <= bus.retire_pc;
      instr_mem[wr_ptr_q] <= bus.retire_instr;
      data_mem[wr_ptr_q]  <= keep_wr ? bus.retire_wr_data : 32'd0;
      seq_mem[wr_ptr_q]   <= seq_q;
      wr_mem[wr_ptr_q]    <= keep_wr;
      dest_mem[wr_ptr_q]  <= keep_wr ? bus.retire_dest : 5'd0;
    end
  end

  logic [31:0] beat_data;

  always_comb begin
    beat_data = 32'd0;
    case (beat_q)
      2'd0:    beat_data = pc_mem[rd_ptr_q];
      2'd1:    beat_data = instr_mem[rd_ptr_q];
      2'd2:    beat_data = {seq_mem[rd_ptr_q], 8'h00, wr_mem[rd_ptr_q], 2'b00,
                            dest_mem[rd_ptr_q]};
      default: beat_data = data_mem[rd_ptr_q];
    endcase
  end

  assign bus.tx_valid = (state_q == StSend);
  assign bus.tx_data  = bus.tx_valid ? beat_data : 32'd0;
  assign bus.tx_last  = bus.tx_valid && (beat_q == 2'd3);
  assign stall_req    = (count_q >= AfCnt);
  assign overflow     = overflow_q;
  assign end_seen     = end_seen_q;
  assign drain_done   = end_seen_q && (count_q == '0) && (state_q == StIdle);
endmodule

// File: tb/tb_retire_trace_tx.sv
// Self-checking bench for retire_trace_tx: a record-level reference model feeds a beat
// scoreboard, and a negedge monitor compares every transfer and status output.
module tb_retire_trace_tx;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF    = 2;

  logic clk = 1'b0;
  logic reset;
  logic stall_req, overflow, end_seen, drain_done;

  always #5 clk = ~clk;

  retire_trace_tx_if bus ();

  retire_trace_tx #(
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .stall_req  (stall_req),
    .overflow   (overflow),
    .end_seen   (end_seen),
    .drain_done (drain_done)
  );

  int          checks   = 0;
  int          failures = 0;
  bit          mon_en   = 1'b0;
  logic [32:0] exp_q[$];
  int          occ      = 0;
  logic [15:0] m_seq    = 16'd0;
  bit          m_ovf    = 1'b0;
  bit          m_end    = 1'b0;
  bit          prev_hold = 1'b0;
  logic [32:0] prev_beat = 33'd0;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy is records accepted minus records whose last beat has left.
  always @(negedge clk) begin
    if (mon_en) begin
      logic        pop;
      logic [32:0] e;
      logic        keep;
      check("tx_valid", {32'd0, bus.tx_valid}, {32'd0, occ > 0});
      check("stall_req", {32'd0, stall_req}, {32'd0, occ >= int'(DEPTH - AF)});
      check("overflow", {32'd0, overflow}, {32'd0, m_ovf});
      check("end_seen", {32'd0, end_seen}, {32'd0, m_end});
      check("drain_done", {32'd0, drain_done}, {32'd0, m_end && occ == 0});
      if (!bus.tx_valid) check("idle_out", {bus.tx_last, bus.tx_data}, 33'd0);
      if (prev_hold) begin
        check("hold_valid", {32'd0, bus.tx_valid}, 33'd1);
        check("hold_data", {bus.tx_last, bus.tx_data}, prev_beat);
      end
      if (reset) begin
        exp_q.delete();
        occ       = 0;
        m_seq     = 16'd0;
        m_ovf     = 1'b0;
        m_end     = 1'b0;
        prev_hold = 1'b0;
      end else begin
        pop = 1'b0;
        if (bus.tx_valid && bus.tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_beat: got %h expected none", {bus.tx_last, bus.tx_data});
          end else begin
            e = exp_q.pop_front();
            check("beat", {bus.tx_last, bus.tx_data}, e);
            pop = e[32];
          end
        end
        if (bus.retire_valid) begin
          if (occ < int'(DEPTH) || pop) begin
            keep = bus.retire_reg_wr && bus.retire_dest != 5'd0;
            exp_q.push_back({1'b0, bus.retire_pc});
            exp_q.push_back({1'b0, bus.retire_instr});
            exp_q.push_back({1'b0, m_seq, 8'h00, keep, 2'b00,
                             keep ? bus.retire_dest : 5'd0});
            exp_q.push_back({1'b1, keep ? bus.retire_wr_data : 32'd0});
            occ++;
            if (bus.retire_instr == 32'hC && bus.v0_val == 32'hA) m_end = 1'b1;
          end else begin
            m_ovf = 1'b1;
          end
          m_seq = m_seq + 16'd1;
        end
        if (pop) occ--;
        prev_hold = bus.tx_valid && !bus.tx_ready;
        prev_beat = {bus.tx_last, bus.tx_data};
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic wr,
                        input logic [4:0] dest, input logic [31:0] data, input logic [31:0] v0);
    bus.retire_valid   = 1'b1;
    bus.retire_pc      = pc;
    bus.retire_instr   = instr;
    bus.retire_reg_wr  = wr;
    bus.retire_dest    = dest;
    bus.retire_wr_data = data;
    bus.v0_val         = v0;
    step();
    bus.retire_valid   = 1'b0;
  endtask

  task automatic retire_rand();
    retire($urandom, $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int waited;
    reset              = 1'b1;
    bus.retire_valid   = 1'b0;
    bus.retire_pc      = '0;
    bus.retire_instr   = '0;
    bus.retire_reg_wr  = 1'b0;
    bus.retire_dest    = '0;
    bus.retire_wr_data = '0;
    bus.v0_val         = '0;
    bus.tx_ready       = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step();
    reset = 1'b0;

    // Single record
    bus.tx_ready = 1'b1;
    retire(32'h0040_0000, 32'h2002_0005, 1'b1, 5'd2, 32'd5, 32'd0);
    repeat (8) step();

    // Backpressure mid-record
    retire_rand();
    step();
    bus.tx_ready = 1'b0;
    repeat (5) step();
    bus.tx_ready = 1'b1;
    repeat (8) step();

    // Fill beyond capacity, then drain and one more record
    do_reset();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH) + 1; i++) retire_rand();
    step();
    bus.tx_ready = 1'b1;
    repeat (40) step();
    retire_rand();
    repeat (8) step();

    // Full FIFO with a retirement on the beat3 handshake
    do_reset();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) retire_rand();
    step();
    bus.tx_ready = 1'b1;
    repeat (3) step();
    retire_rand();
    repeat (40) step();

    // Store-like record with dest 0
    retire(32'h0040_0010, 32'hAC02_0000, 1'b1, 5'd0, 32'h1234, 32'd0);
    repeat (8) step();

    // End-of-program syscall, two more records, drain
    do_reset();
    bus.tx_ready = 1'b1;
    retire(32'h0040_0020, 32'h0000_000C, 1'b0, 5'd0, 32'd0, 32'hA);
    retire_rand();
    retire_rand();
    repeat (16) step();
    // Reset while beat1 is on the bus
    retire_rand();
    step();
    do_reset();
    repeat (3) step();

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      bus.retire_valid   = 1'($urandom_range(0, 1));
      bus.retire_pc      = $urandom;
      bus.retire_reg_wr  = 1'($urandom_range(0, 1));
      bus.retire_dest    = 5'($urandom_range(0, 31));
      bus.retire_wr_data = $urandom;
      if ($urandom_range(0, 15) == 0) begin
        bus.retire_instr = 32'hC;
        bus.v0_val       = ($urandom_range(0, 1) == 0) ? 32'hA : 32'h4;
      end else begin
        bus.retire_instr = $urandom;
        bus.v0_val       = $urandom;
      end
      bus.tx_ready = ($urandom_range(0, 9) < 6);
      reset        = ($urandom_range(0, 299) == 0);
      step();
    end
    reset            = 1'b0;
    bus.retire_valid = 1'b0;
    bus.tx_ready     = 1'b1;

    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      step();
      waited++;
    end
    step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
